// File: rtl/uart_pkg.sv
// Shared UART definitions: RX state encoding, frame constants and bit-timing helpers.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        RX_PARITY    = 3'd3,
`endif
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } rx_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clock_hz,
                                                 input int unsigned baud);
        return clock_hz / baud;
    endfunction

    // Counter value at which the middle of the start bit is reached.
    function automatic int unsigned half_bit(input int unsigned clock_hz,
                                             input int unsigned baud);
        return (clks_per_bit(clock_hz, baud) - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops
// reset to RESET_VAL so the output reads as that level straight out of reset.
module uart_sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_d,
    output logic o_q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, 8N1 by default; defining UART_RX_PARITY_EN adds a
// parity bit (8E1/8O1 via PARITY_ODD) and the o_rx_parity_err strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
    parameter int unsigned BAUD_RATE       = 9600,
    parameter bit          PARITY_ODD      = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_rx_serial,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_active,
    output logic       o_rx_frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       o_rx_parity_err
`endif
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int unsigned HALF         = half_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifndef UART_RX_PARITY_EN
    // Without a parity bit the odd/even selection has nothing to act on.
    localparam bit unused_parity_odd = PARITY_ODD;
`endif

    logic rx_s;

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 dv_q, dv_d;
    logic                 frame_err_q, frame_err_d;
    logic                 active;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 par_err_q, par_err_d;
`endif

    uart_sync_2ff #(
        .RESET_VAL(IDLE_LEVEL)
    ) u_sync (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_d    (i_rx_serial),
        .o_q    (rx_s)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= RX_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_q      <= '0;
            dv_q        <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_q      <= byte_d;
            dv_q        <= dv_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= par_bad_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_d      = byte_q;
        dv_d        = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad_q;
        par_err_d   = 1'b0;
`endif
        case (state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (rx_s != IDLE_LEVEL) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (clk_cnt_q == CNT_HALF) begin
                    clk_cnt_d = '0;
                    state_d   = (rx_s != IDLE_LEVEL) ? RX_DATA : RX_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    par_bad_d = rx_s ^ (^shift_q) ^ PARITY_ODD;
                    state_d   = RX_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`endif
            RX_STOP: begin
                // Leaving at mid-stop-bit lets an immediately following start bit be caught.
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s == IDLE_LEVEL) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
                        par_err_d = par_bad_q;
`endif
                        state_d = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RX_WAIT_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_s == IDLE_LEVEL) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    always_comb begin
        active = (state_q != RX_IDLE) && (state_q != RX_WAIT_IDLE);
    end

    assign o_rx_dv        = dv_q;
    assign o_rx_byte      = byte_q;
    assign o_rx_active    = active;
    assign o_rx_frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign o_rx_parity_err = par_err_q;
`endif

endmodule
